// File: rtl/sdram_resp_model.sv
// SDR SDRAM device-side responder: decodes bus commands, tracks open rows per bank,
// and returns read bursts through a CAS-latency-deep pipeline.
module sdram_resp_model #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int ROW_W  = 4,
  parameter int COL_W  = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cs_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [1:0]        ba,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] dq_in,
  input  logic [1:0]        dqm,
  output logic [DATA_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              err
);

  localparam int MEM_AW = 2 + ROW_W + COL_W;
  localparam int HALF   = DATA_W / 2;

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_BST = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } burst_st_e;

  cmd_e                cmd;
  burst_st_e           state_q, state_d;

  logic [3:0]          bank_act_q;
  logic [ROW_W-1:0]    bank_row_q [4];
  logic                cl3_q;
  logic [1:0]          bl_code_q;

  logic [1:0]          burst_ba_q;
  logic [ROW_W-1:0]    burst_row_q;
  logic [COL_W-1:0]    burst_col_q;
  logic [2:0]          burst_cnt_q, burst_cnt_d;

  logic                p0_vld_q, p1_vld_q;
  logic [DATA_W-1:0]   p0_dat_q, p1_dat_q;
  logic                dq_oe_q, err_q;
  logic [DATA_W-1:0]   dq_out_q;

  logic                violation, act_set, mode_load;
  logic                start_rd, start_wr, stop_burst;
  logic [3:0]          pre_mask;

  logic                issue, issue_wr;
  logic [1:0]          iss_ba;
  logic [ROW_W-1:0]    iss_row;
  logic [COL_W-1:0]    iss_col, burst_col_cur, bl_mask;
  logic [2:0]          last_idx;
  logic [MEM_AW-1:0]   mem_idx;
  logic [DATA_W-1:0]   rd_word, wr_word;

  logic [DATA_W-1:0]   mem [2**MEM_AW];

  // Only a handful of address bits carry meaning in this small device.
  logic unused_addr;
  assign unused_addr = ^addr;

  assign cmd = cs_n ? CMD_NOP : cmd_e'({ras_n, cas_n, we_n});

  assign last_idx = 3'((4'd1 << bl_code_q) - 4'd1);
  assign bl_mask  = COL_W'(last_idx);

  // Sequential wrap: low log2(BL) column bits count mod BL, upper bits stay put.
  assign burst_col_cur = (burst_col_q & ~bl_mask)
                       | ((burst_col_q + COL_W'(burst_cnt_q)) & bl_mask);

  // Command decode and protocol checking.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    violation  = 1'b0;
    act_set    = 1'b0;
    mode_load  = 1'b0;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    stop_burst = 1'b0;
    pre_mask   = 4'b0000;
    case (cmd)
      CMD_ACT: begin
        if (bank_act_q[ba]) violation = 1'b1;
        else                act_set   = 1'b1;
      end
      CMD_RD: begin
        if (!bank_act_q[ba]) violation = 1'b1;
        else                 start_rd  = 1'b1;
      end
      CMD_WR: begin
        if (!bank_act_q[ba]) violation = 1'b1;
        else                 start_wr  = 1'b1;
      end
      CMD_PRE: pre_mask = addr[10] ? 4'b1111 : (4'b0001 << ba);
      CMD_REF: begin
        if (|bank_act_q) violation = 1'b1;
      end
      CMD_LMR: begin
        if (|bank_act_q || addr[2] || (addr[6:5] != 2'b01)) violation = 1'b1;
        else                                               mode_load = 1'b1;
      end
      CMD_BST: stop_burst = 1'b1;
      default: ;
    endcase
    if (pre_mask[burst_ba_q]) stop_burst = 1'b1;
  end

  // Burst sequencer: decides which word (if any) is issued on this edge.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    issue       = 1'b0;
    issue_wr    = 1'b0;
    iss_ba      = burst_ba_q;
    iss_row     = burst_row_q;
    iss_col     = burst_col_cur;
    if (start_rd || start_wr) begin
      issue       = 1'b1;
      issue_wr    = start_wr;
      iss_ba      = ba;
      iss_row     = bank_row_q[ba];
      iss_col     = addr[COL_W-1:0];
      burst_cnt_d = 3'd1;
      if (last_idx == 3'd0) state_d = ST_IDLE;
      else                  state_d = start_wr ? ST_WRITE : ST_READ;
    end else if (state_q != ST_IDLE) begin
      if (stop_burst) begin
        state_d = ST_IDLE;
      end else begin
        issue       = 1'b1;
        issue_wr    = (state_q == ST_WRITE);
        burst_cnt_d = burst_cnt_q + 3'd1;
        if (burst_cnt_q == last_idx) state_d = ST_IDLE;
      end
    end
  end

  assign mem_idx = {iss_ba, iss_row, iss_col};
  assign rd_word = mem[mem_idx];
  assign wr_word = {dqm[1] ? rd_word[DATA_W-1:HALF] : dq_in[DATA_W-1:HALF],
                    dqm[0] ? rd_word[HALF-1:0]      : dq_in[HALF-1:0]};

  // NOTE: the storage array has no reset; its contents survive Reset by design.
  always_ff @(posedge Clk) begin
    if (issue && issue_wr) mem[mem_idx] <= wr_word;
  end

  // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= 3'd0;
      burst_ba_q  <= 2'd0;
      burst_row_q <= '0;
      burst_col_q <= '0;
      bank_act_q  <= 4'b0000;
      for (int b = 0; b < 4; b++) bank_row_q[b] <= '0;
      cl3_q       <= 1'b1;
      bl_code_q   <= 2'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= violation;
      if (start_rd || start_wr) begin
        burst_ba_q  <= ba;
        burst_row_q <= bank_row_q[ba];
        burst_col_q <= addr[COL_W-1:0];
      end
      bank_act_q <= (bank_act_q & ~pre_mask) | (act_set ? (4'b0001 << ba) : 4'b0000);
      if (act_set) bank_row_q[ba] <= addr[ROW_W-1:0];
      if (mode_load) begin
        cl3_q     <= addr[4];
        bl_code_q <= addr[1:0];
      end
    end
  end

  // Read pipeline: CL=3 words enter one stage further back than CL=2 words.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      p0_dat_q <= '0;
      p1_dat_q <= '0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else if (start_wr) begin
      p0_vld_q <= 1'b0;
      p1_vld_q <= 1'b0;
      dq_oe_q  <= 1'b0;
      dq_out_q <= '0;
    end else begin
      dq_oe_q  <= p0_vld_q;
      dq_out_q <= p0_vld_q ? p0_dat_q : '0;
      p0_vld_q <= p1_vld_q;
      p0_dat_q <= p1_dat_q;
      p1_vld_q <= 1'b0;
      if (issue && !issue_wr) begin
        if (cl3_q) begin
          p1_vld_q <= 1'b1;
          p1_dat_q <= rd_word;
        end else begin
          p0_vld_q <= 1'b1;
          p0_dat_q <= rd_word;
        end
      end
    end
  end

  assign dq_out = dq_out_q;
  assign dq_oe  = dq_oe_q;
  assign err    = err_q;

endmodule

// File: tb/tb_sdram_resp_model.sv
// Directed bench for sdram_resp_model: inputs change on the falling edge and
// outputs are observed there, i.e. the state left by the preceding rising edge.
module tb_sdram_resp_model;

  localparam logic [2:0] C_LMR = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111;

  logic        Clk, Reset, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba, dqm;
  logic [11:0] addr;
  logic [15:0] dq_in, dq_out;
  logic        dq_oe, err;

  int vectors = 0;
  int miscompares = 0;

  sdram_resp_model #(.DATA_W(16), .ADDR_W(12), .ROW_W(4), .COL_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .cs_n(cs_n), .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n),
    .ba(ba), .addr(addr), .dq_in(dq_in), .dqm(dqm),
    .dq_out(dq_out), .dq_oe(dq_oe), .err(err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Present one command for one rising edge, return at the following falling edge.
  task automatic step(input logic [2:0] c, input logic [1:0] b, input logic [11:0] a,
                      input logic [15:0] d, input logic [1:0] m);
    cs_n = 1'b0;
    {ras_n, cas_n, we_n} = c;
    ba = b; addr = a; dq_in = d; dqm = m;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    #12;
    vectors++; if (dq_out !== 16'h0) begin miscompares++; $display("FAIL reset dq_out: got %h want 0000", dq_out); end
    vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL reset dq_oe: got %b want 0", dq_oe); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset err: got %b want 0", err); end
    @(negedge Clk);
    Reset = 1'b1;
    step(C_NOP, 0, 0, 0, 0);
    vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL post-reset dq_oe: got %b want 0", dq_oe); end
  endtask

  task automatic test_cl2_bl4();
    logic        exp_oe [0:5];
    logic [15:0] exp_d  [0:5];
    exp_oe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d  = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0};
    step(C_LMR, 0, 12'h022, 0, 0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL cl2 lmr err: got %b want 0", err); end
    step(C_ACT, 1, 12'h005, 0, 0);
    step(C_WR,  1, 12'h000, 16'h1111, 0);
    step(C_NOP, 0, 0, 16'h2222, 0);
    step(C_NOP, 0, 0, 16'h3333, 0);
    step(C_NOP, 0, 0, 16'h4444, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 0) step(C_RD, 1, 12'h000, 0, 0);
      else        step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL cl2 oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== exp_d[i]) begin miscompares++; $display("FAIL cl2 data[%0d]: got %h want %h", i, dq_out, exp_d[i]); end
      end
    end
  endtask

  task automatic test_cl3_wrap();
    logic        exp_oe [0:6];
    logic [15:0] exp_d  [0:6];
    exp_oe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d  = '{16'h0, 16'h0, 16'h3333, 16'h4444, 16'h1111, 16'h2222, 16'h0};
    step(C_PRE, 0, 12'h400, 0, 0);
    step(C_LMR, 0, 12'h032, 0, 0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL cl3 lmr err: got %b want 0", err); end
    step(C_ACT, 1, 12'h005, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 0) step(C_RD, 1, 12'h002, 0, 0);
      else        step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL cl3 oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== exp_d[i]) begin miscompares++; $display("FAIL cl3 data[%0d]: got %h want %h", i, dq_out, exp_d[i]); end
      end
    end
  endtask

  task automatic test_dqm();
    logic exp_oe [0:4];
    exp_oe = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    step(C_WR,  1, 12'h004, 16'h1234, 2'b00);
    step(C_BST, 0, 0, 16'hFFFF, 2'b00);
    step(C_WR,  1, 12'h004, 16'hABCD, 2'b10);
    step(C_BST, 0, 0, 16'hFFFF, 2'b00);
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      step(C_RD,  1, 12'h004, 0, 0);
      else if (i == 1) step(C_BST, 0, 0, 0, 0);
      else             step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL dqm oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== 16'h12CD) begin miscompares++; $display("FAIL dqm data: got %h want 12cd", dq_out); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_oe [0:12];
    logic [15:0] exp_d  [0:12];
    exp_oe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d  = '{16'h0, 16'h0, 16'h2000, 16'h2001, 16'h2004, 16'h2005, 16'h2006,
               16'h2007, 16'h2000, 16'h2001, 16'h2002, 16'h2003, 16'h0};
    step(C_PRE, 0, 12'h400, 0, 0);
    step(C_LMR, 0, 12'h033, 0, 0);
    step(C_ACT, 2, 12'h003, 0, 0);
    step(C_WR,  2, 12'h000, 16'h2000, 0);
    for (int i = 1; i < 8; i++) step(C_NOP, 0, 0, 16'h2000 + 16'(i), 0);
    for (int i = 0; i < 13; i++) begin
      if (i == 0)      step(C_RD, 2, 12'h000, 0, 0);
      else if (i == 2) step(C_RD, 2, 12'h004, 0, 0);
      else             step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL b2b oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== exp_d[i]) begin miscompares++; $display("FAIL b2b data[%0d]: got %h want %h", i, dq_out, exp_d[i]); end
      end
    end
  endtask

  task automatic test_burst_terminate();
    logic        exp_oe [0:6];
    logic [15:0] exp_d  [0:6];
    exp_oe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d  = '{16'h0, 16'h0, 16'h2006, 16'h2007, 16'h2000, 16'h0, 16'h0};
    for (int i = 0; i < 7; i++) begin
      if (i == 0)      step(C_RD,  2, 12'h006, 0, 0);
      else if (i == 3) step(C_BST, 0, 0, 0, 0);
      else             step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL bst oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== exp_d[i]) begin miscompares++; $display("FAIL bst data[%0d]: got %h want %h", i, dq_out, exp_d[i]); end
      end
    end
  endtask

  task automatic test_errors();
    logic exp_oe [0:10];
    exp_oe = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    step(C_RD, 0, 12'h000, 0, 0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err idle read: got %b want 1", err); end
    for (int i = 0; i < 4; i++) begin
      step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (err !== 1'b0 || dq_oe !== 1'b0) begin
        miscompares++; $display("FAIL err idle read tail[%0d]: got err=%b oe=%b want 0 0", i, err, dq_oe);
      end
    end
    step(C_ACT, 2, 12'h003, 0, 0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err double act: got %b want 1", err); end
    step(C_NOP, 0, 0, 0, 0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err double act pulse: got %b want 0", err); end
    step(C_REF, 0, 0, 0, 0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err refresh open: got %b want 1", err); end
    step(C_NOP, 0, 0, 0, 0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err refresh pulse: got %b want 0", err); end
    step(C_PRE, 0, 12'h400, 0, 0);
    step(C_LMR, 0, 12'h052, 0, 0);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err cl code 5: got %b want 1", err); end
    step(C_NOP, 0, 0, 0, 0);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err cl code pulse: got %b want 0", err); end
    step(C_ACT, 2, 12'h003, 0, 0);
    for (int i = 0; i < 11; i++) begin
      if (i == 0) step(C_RD, 2, 12'h000, 0, 0);
      else        step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL mode kept oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== 16'h2000 + 16'(i - 2)) begin
          miscompares++; $display("FAIL mode kept data[%0d]: got %h want %h", i, dq_out, 16'h2000 + 16'(i - 2));
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic exp_oe [0:3];
    exp_oe = '{1'b0, 1'b0, 1'b1, 1'b0};
    step(C_RD,  2, 12'h000, 0, 0);
    step(C_NOP, 0, 0, 0, 0);
    step(C_NOP, 0, 0, 0, 0);
    vectors++; if (dq_oe !== 1'b1) begin miscompares++; $display("FAIL pre-reset oe: got %b want 1", dq_oe); end
    cs_n = 1'b1;
    #2 Reset = 1'b0;
    #1;
    vectors++; if (dq_oe !== 1'b0) begin miscompares++; $display("FAIL async reset oe: got %b want 0", dq_oe); end
    vectors++; if (dq_out !== 16'h0) begin miscompares++; $display("FAIL async reset dq_out: got %h want 0000", dq_out); end
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    step(C_ACT, 2, 12'h003, 0, 0);
    step(C_WR,  2, 12'h005, 16'h5A5A, 0);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) step(C_RD, 2, 12'h005, 0, 0);
      else        step(C_NOP, 0, 0, 0, 0);
      vectors++;
      if (dq_oe !== exp_oe[i]) begin miscompares++; $display("FAIL post-reset read oe[%0d]: got %b want %b", i, dq_oe, exp_oe[i]); end
      if (exp_oe[i]) begin
        vectors++;
        if (dq_out !== 16'h5A5A) begin miscompares++; $display("FAIL post-reset read data: got %h want 5a5a", dq_out); end
      end
    end
  endtask

  initial begin
    Reset = 1'b0;
    cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
    ba = '0; addr = '0; dq_in = '0; dqm = '0;
    test_reset();
    test_cl2_bl4();
    test_cl3_wrap();
    test_dqm();
    test_back_to_back();
    test_burst_terminate();
    test_errors();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
